// File: rtl/pc_channel_arbiter_rr.sv
// N-input arbiter for the PC/CC-id channel: input 0 optional strict-priority override,
// remaining inputs round-robin, 2-entry registered output buffer and per-input grant counters.
module pc_channel_arbiter_rr #(
    parameter int N_IN            = 4,
    parameter int DWIDTH          = 9,
    parameter int PRIORITY_IN0    = 1,
    parameter int GRANT_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_IN-1:0]                   in_valid,
    input  logic [N_IN*DWIDTH-1:0]            in_data,
    output logic [N_IN-1:0]                   in_ready,
    output logic                              out_valid,
    output logic [DWIDTH-1:0]                 out_data,
    input  logic                              out_ready,
    output logic                              idle,
    output logic [N_IN*GRANT_CNT_WIDTH-1:0]   grant_count
);

    localparam int              PTR_W    = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam bit              PRIO     = (PRIORITY_IN0 != 0);
    localparam logic [PTR_W-1:0] RR_FIRST = PRIO ? PTR_W'(1) : '0;
    localparam logic [PTR_W-1:0] RR_LAST  = PTR_W'(N_IN - 1);

    logic [1:0]                 count_q, count_d;
    logic [DWIDTH-1:0]          head_q, head_d;
    logic [DWIDTH-1:0]          tail_q, tail_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GRANT_CNT_WIDTH-1:0] gcnt_q [N_IN];

    logic [N_IN-1:0]            grant;
    logic [PTR_W-1:0]           grant_idx;
    logic                       grant_any;
    logic                       accept_en;
    logic                       push;
    logic                       pop;
    logic [DWIDTH-1:0]          push_data;

    // Grant looks only at in_valid and registered state, so in_ready never depends on out_ready.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        if (PRIO && in_valid[0]) begin
            grant[0]  = 1'b1;
            grant_any = 1'b1;
        end else begin
            for (int off = 0; off < N_IN; off++) begin
                sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
                if (sum >= (PTR_W+1)'(N_IN)) sum = sum - (PTR_W+1)'(N_IN);
                cand = sum[PTR_W-1:0];
                if (!grant_any && in_valid[cand] && !(PRIO && cand == '0)) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    grant_any   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) push_data = push_data | in_data[i*DWIDTH +: DWIDTH];
        end
    end

    assign accept_en = (count_q != 2'd2);
    assign in_ready  = accept_en ? grant : '0;
    assign push      = accept_en && grant_any;
    assign pop       = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        rr_ptr_d = rr_ptr_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data;
                else                 tail_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Simultaneous push/pop only happens at count 1: new data replaces the head.
            2'b11:   head_d = push_data;
            default: ;
        endcase
        if (push && !(PRIO && grant_idx == '0)) begin
            rr_ptr_d = (grant_idx == RR_LAST) ? RR_FIRST : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count_q  <= 2'd0;
            head_q   <= '0;
            rr_ptr_q <= RR_FIRST;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // NOTE: the second buffer slot is never observed while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (rst) begin
                gcnt_q[i] <= '0;
            end else if (push && grant[i] && gcnt_q[i] != '1) begin
                gcnt_q[i] <= gcnt_q[i] + GRANT_CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N_IN; i++) begin
            grant_count[i*GRANT_CNT_WIDTH +: GRANT_CNT_WIDTH] = gcnt_q[i];
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign idle      = (count_q == 2'd0) && (in_valid == '0);

endmodule

// File: tb/tb_pc_channel_arbiter_rr.sv
// Directed bench for pc_channel_arbiter_rr: reset, round-robin order, priority override,
// backpressure, mid-operation reset and grant-counter saturation (4-bit counters).
module tb_pc_channel_arbiter_rr;

    localparam int N_IN   = 4;
    localparam int DWIDTH = 9;
    localparam int GCW    = 4;

    logic                   clk;
    logic                   rst;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN*DWIDTH-1:0] in_data;
    logic [N_IN-1:0]        in_ready;
    logic                   out_valid;
    logic [DWIDTH-1:0]      out_data;
    logic                   out_ready;
    logic                   idle;
    logic [N_IN*GCW-1:0]    grant_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] rr_ready [3];
    logic [8:0] rr_data  [3];
    logic [3:0] p_ready  [8];
    logic [8:0] p_data   [8];

    pc_channel_arbiter_rr #(
        .N_IN            (N_IN),
        .DWIDTH          (DWIDTH),
        .PRIORITY_IN0    (1),
        .GRANT_CNT_WIDTH (GCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .idle        (idle),
        .grant_count (grant_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [8:0] d);
        in_data[i*DWIDTH +: DWIDTH] = d;
    endtask

    function automatic logic [GCW-1:0] gcnt(input int i);
        return grant_count[i*GCW +: GCW];
    endfunction

    initial begin
        rr_ready = '{4'b0010, 4'b0100, 4'b1000};
        rr_data  = '{9'h011, 9'h022, 9'h033};
        p_ready  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
        p_data   = '{9'h011, 9'h022, 9'h033, 9'h1FF, 9'h1FF, 9'h1FF, 9'h011, 9'h022};

        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Quiet after reset
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_out_valid", 64'(out_valid), 64'(1'b0));
            check("rst_out_data", 64'(out_data), 64'(9'h000));
            check("rst_in_ready", 64'(in_ready), 64'(4'b0000));
            check("rst_idle", 64'(idle), 64'(1'b1));
            check("rst_gcnt", 64'(grant_count), 64'(16'h0000));
        end

        // Round-robin over inputs 1..3, sustained one transfer per cycle
        set_data(1, 9'h011); set_data(2, 9'h022); set_data(3, 9'h033);
        in_valid = 4'b1110; out_ready = 1'b1;
        #1;
        check("rr_idle_busy", 64'(idle), 64'(1'b0));
        for (int k = 0; k < 9; k++) begin
            check("rr_in_ready", 64'(in_ready), 64'(rr_ready[k % 3]));
            tick();
            check("rr_out_valid", 64'(out_valid), 64'(1'b1));
            check("rr_out_data", 64'(out_data), 64'(rr_data[k % 3]));
        end
        check("rr_gcnt0", 64'(gcnt(0)), 64'(4'd0));
        check("rr_gcnt1", 64'(gcnt(1)), 64'(4'd3));
        check("rr_gcnt2", 64'(gcnt(2)), 64'(4'd3));
        check("rr_gcnt3", 64'(gcnt(3)), 64'(4'd3));
        in_valid = '0;
        tick();
        check("rr_drain_valid", 64'(out_valid), 64'(1'b0));
        check("rr_drain_idle", 64'(idle), 64'(1'b1));

        // Priority override on input 0 for three cycles; RR resumes where it paused
        set_data(0, 9'h1FF);
        for (int c = 0; c < 8; c++) begin
            in_valid = {3'b111, (c >= 3 && c <= 5)};
            #1;
            check("prio_in_ready", 64'(in_ready), 64'(p_ready[c]));
            tick();
            check("prio_out_data", 64'(out_data), 64'(p_data[c]));
        end
        in_valid = '0;
        tick();
        check("prio_drain_valid", 64'(out_valid), 64'(1'b0));
        check("prio_gcnt0", 64'(gcnt(0)), 64'(4'd3));
        check("prio_gcnt1", 64'(gcnt(1)), 64'(4'd5));
        check("prio_gcnt2", 64'(gcnt(2)), 64'(4'd5));
        check("prio_gcnt3", 64'(gcnt(3)), 64'(4'd4));

        // Backpressure: two entries accepted, then hold; drain in order
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        set_data(2, 9'h0A1);
        #1;
        check("bp_ready_0", 64'(in_ready), 64'(4'b0100));
        tick();
        check("bp_first_head", 64'(out_data), 64'(9'h0A1));
        set_data(2, 9'h0A2);
        #1;
        check("bp_ready_1", 64'(in_ready), 64'(4'b0100));
        tick();
        set_data(2, 9'h0A3);
        #1;
        check("bp_full_ready", 64'(in_ready), 64'(4'b0000));
        for (int c = 0; c < 2; c++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'(1'b1));
            check("bp_hold_data", 64'(out_data), 64'(9'h0A1));
            check("bp_hold_ready", 64'(in_ready), 64'(4'b0000));
        end
        out_ready = 1'b1;
        tick();
        check("bp_pop_full_data", 64'(out_data), 64'(9'h0A2));
        check("bp_pop_full_ready", 64'(in_ready), 64'(4'b0100));
        tick();
        check("bp_pushpop_data", 64'(out_data), 64'(9'h0A3));
        in_valid = '0;
        tick();
        check("bp_empty_valid", 64'(out_valid), 64'(1'b0));
        check("bp_gcnt2", 64'(gcnt(2)), 64'(4'd8));

        // Reset with two entries buffered and rr_ptr moved to 3
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        set_data(2, 9'h0B2);
        tick(); tick();
        check("mr_full_valid", 64'(out_valid), 64'(1'b1));
        check("mr_full_ready", 64'(in_ready), 64'(4'b0000));
        rst = 1'b1; in_valid = '0;
        tick();
        rst = 1'b0;
        check("mr_out_valid", 64'(out_valid), 64'(1'b0));
        check("mr_out_data", 64'(out_data), 64'(9'h000));
        check("mr_idle", 64'(idle), 64'(1'b1));
        check("mr_gcnt", 64'(grant_count), 64'(16'h0000));
        in_valid = 4'b1110;
        #1;
        check("mr_rr_restart", 64'(in_ready), 64'(4'b0010));
        tick();
        check("mr_first_data", 64'(out_data), 64'(9'h011));

        // Saturation of input 1 counter (one transfer already counted above)
        in_valid = 4'b0010; out_ready = 1'b1;
        for (int c = 0; c < 13; c++) tick();
        check("sat_gcnt1_14", 64'(gcnt(1)), 64'(4'd14));
        for (int c = 0; c < 6; c++) tick();
        check("sat_gcnt1_15", 64'(gcnt(1)), 64'(4'd15));
        check("sat_gcnt0", 64'(gcnt(0)), 64'(4'd0));
        check("sat_gcnt2", 64'(gcnt(2)), 64'(4'd0));
        check("sat_gcnt3", 64'(gcnt(3)), 64'(4'd0));
        check("sat_out_data", 64'(out_data), 64'(9'h011));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
